// File: rtl/blackjack_timer_pkg.sv
// Shared timer definitions for the blackjack game FSMs: timer state encoding
// and the tick counts the game FSMs use to build delay lengths.
package blackjack_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } timer_state_e;

  localparam int CLK_DIV_2K  = 25000;  // clk_50M cycles per 2 kHz tick
  localparam int TICKS_2SEC  = 4000;
  localparam int TICKS_500MS = 1000;

endpackage

// File: rtl/delay_timer_arbiter_if.sv
// Request/grant bundle between the game FSMs (master) and the shared delay timer (slave).
interface delay_timer_arbiter_if #(
  parameter int N_REQ = 3,
  parameter int WIDTH = 12
);
  import blackjack_timer_pkg::*;

  // Handshake: a requester raises i_Req[k] with its length on i_Len slice k and
  // holds it until o_Done[k] pulses; dropping it while granted aborts the delay.
  logic [N_REQ-1:0]       i_Req;
  logic [N_REQ*WIDTH-1:0] i_Len;
  logic [N_REQ-1:0]       o_Grant;
  logic [N_REQ-1:0]       o_Done;
  logic                   o_Busy;
  logic [WIDTH-1:0]       o_Count;
  logic                   o_Tick;
  timer_state_e           state;

  modport master (
    output i_Req, i_Len,
    input  o_Grant, o_Done, o_Busy, o_Count, o_Tick, state
  );

  modport slave (
    input  i_Req, i_Len,
    output o_Grant, o_Done, o_Busy, o_Count, o_Tick, state
  );

endinterface

// File: rtl/delay_timer_arbiter_tick_prescaler.sv
// Divide-by-CLK_DIV prescaler with synchronous clear and enable; strobes tick on the last count.
module tick_prescaler #(
  parameter int CLK_DIV = 25000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tick = en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/delay_timer_arbiter.sv
// One tick-based delay timer shared round-robin between N_REQ game FSMs,
// all in the clk_50M domain.
module delay_timer_arbiter
  import blackjack_timer_pkg::*;
#(
  parameter int N_REQ   = 3,
  parameter int WIDTH   = 12,
  parameter int CLK_DIV = CLK_DIV_2K
) (
  input  logic                  clk_50M,
  input  logic                  i_Reset,
  delay_timer_arbiter_if.slave  bus
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  timer_state_e     state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] len_q, len_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [IW-1:0]    pick;
  logic             found;
  logic             tick;

  tick_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
    .clk  (clk_50M),
    .rst  (i_Reset),
    .clr  (state_q != ST_RUN),
    .en   (state_q == ST_RUN),
    .tick (tick)
  );

  // First requester after the last owner, wrapping around.
  always_comb begin : arb
    int idx;
    idx   = 0;
    pick  = ptr_q;
    found = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = (int'(ptr_q) + i) % N_REQ;
      if (!found && bus.i_Req[idx]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    done_d  = '0;
    count_d = count_q;
    len_d   = len_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d       = ST_RUN;
          owner_d       = pick;
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          len_d         = bus.i_Len[int'(pick)*WIDTH +: WIDTH];
          count_d       = '0;
        end
      end
      ST_RUN: begin
        // An abort wins over a coincident final tick: the owner gave up.
        if (!bus.i_Req[owner_q]) begin
          state_d = ST_IDLE;
          grant_d = '0;
          ptr_d   = owner_q;
        end else if (len_q == '0) begin
          state_d = ST_DONE;
          done_d  = grant_q;
        end else if (tick) begin
          count_d = count_q + WIDTH'(1);
          if (count_q == len_q - WIDTH'(1)) begin
            state_d = ST_DONE;
            done_d  = grant_q;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        grant_d = '0;
        ptr_d   = owner_q;
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_50M) begin
    if (i_Reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      done_q  <= '0;
      count_q <= '0;
      len_q   <= '0;
      ptr_q   <= IW'(N_REQ - 1);
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      count_q <= count_d;
      len_q   <= len_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

  assign bus.o_Grant = grant_q;
  assign bus.o_Done  = done_q;
  assign bus.o_Busy  = (state_q != ST_IDLE);
  assign bus.o_Count = count_q;
  assign bus.o_Tick  = tick;
  assign bus.state   = state_q;

endmodule

// File: tb/tb_delay_timer_arbiter.sv
// Directed bench for delay_timer_arbiter with CLK_DIV=4, N_REQ=3, WIDTH=12.
module tb_delay_timer_arbiter;
  import blackjack_timer_pkg::*;

  localparam int N_REQ   = 3;
  localparam int WIDTH   = 12;
  localparam int CLK_DIV = 4;

  logic clk_50M;
  logic i_Reset;
  int   n_checks;
  int   n_fail;
  logic [N_REQ-1:0] exp_q[$];

  delay_timer_arbiter_if #(.N_REQ(N_REQ), .WIDTH(WIDTH)) bus ();

  delay_timer_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .CLK_DIV(CLK_DIV)) dut (
    .clk_50M (clk_50M),
    .i_Reset (i_Reset),
    .bus     (bus)
  );

  // clock / reset
  initial clk_50M = 1'b0;
  always #10 clk_50M = ~clk_50M;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one cycle; inputs driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk_50M);
    #1;
  endtask

  task automatic set_len(input int k, input logic [WIDTH-1:0] v);
    bus.i_Len[k*WIDTH +: WIDTH] = v;
  endtask

  initial begin
    logic [N_REQ-1:0] cur;
    logic [N_REQ-1:0] exp_g;
    int ph;
    int done_cyc;

    n_checks  = 0;
    n_fail    = 0;
    cur       = '0;
    bus.i_Req = '0;
    bus.i_Len = '0;
    i_Reset   = 1'b1;

    // reset state
    step();
    step();
    check_eq("rst_grant", 32'(bus.o_Grant), 0);
    check_eq("rst_done",  32'(bus.o_Done),  0);
    check_eq("rst_busy",  32'(bus.o_Busy),  0);
    check_eq("rst_count", 32'(bus.o_Count), 0);
    check_eq("rst_tick",  32'(bus.o_Tick),  0);
    check_eq("rst_state", 32'(bus.state),   32'(ST_IDLE));

    // single request, L0=3: grant 1, ticks 4/8/12, done 13, idle 14
    i_Reset = 1'b0;
    set_len(0, 12'd3);
    bus.i_Req = 3'b001;
    for (int c = 1; c <= 14; c++) begin
      step();
      check_eq("t1_tick", 32'(bus.o_Tick), (c == 4 || c == 8 || c == 12) ? 1 : 0);
      check_eq("t1_done", 32'(bus.o_Done), (c == 13) ? 1 : 0);
      if (c == 1) begin
        check_eq("t1_grant", 32'(bus.o_Grant), 1);
        check_eq("t1_count0", 32'(bus.o_Count), 0);
      end
      if (c == 5) check_eq("t1_count1", 32'(bus.o_Count), 1);
      if (c == 13) begin
        check_eq("t1_grant_done", 32'(bus.o_Grant), 1);
        check_eq("t1_count3", 32'(bus.o_Count), 3);
        bus.i_Req = '0;
      end
      if (c == 14) begin
        check_eq("t1_grant_off", 32'(bus.o_Grant), 0);
        check_eq("t1_busy_off", 32'(bus.o_Busy), 0);
        check_eq("t1_count_hold", 32'(bus.o_Count), 3);
      end
    end

    // round-robin, all L=1, 111 held: grants at 1,7,13,19 to 0,1,2,0
    i_Reset = 1'b1;
    step();
    i_Reset = 1'b0;
    set_len(0, 12'd1);
    set_len(1, 12'd1);
    set_len(2, 12'd1);
    bus.i_Req = 3'b111;
    exp_q.push_back(3'b001);
    exp_q.push_back(3'b010);
    exp_q.push_back(3'b100);
    exp_q.push_back(3'b001);
    for (int c = 1; c <= 23; c++) begin
      step();
      ph = (c - 1) % 6;
      if (ph == 0 && exp_q.size() > 0) cur = exp_q.pop_front();
      exp_g = (ph <= 4) ? cur : '0;
      check_eq("rr_grant", 32'(bus.o_Grant), 32'(exp_g));
      check_eq("rr_done", 32'(bus.o_Done), (ph == 4) ? 32'(cur) : 0);
      check_eq("rr_onehot", ($countones(bus.o_Grant) <= 1) ? 1 : 0, 1);
      if (c == 23) bus.i_Req = '0;
    end
    check_eq("rr_queue_empty", 32'(exp_q.size()), 0);
    step();

    // zero length on requester 1: grant 1, done 2, no tick
    set_len(1, 12'd0);
    bus.i_Req = 3'b010;
    step();
    check_eq("z_grant", 32'(bus.o_Grant), 32'(3'b010));
    check_eq("z_count_clr", 32'(bus.o_Count), 0);
    check_eq("z_tick1", 32'(bus.o_Tick), 0);
    step();
    check_eq("z_done", 32'(bus.o_Done), 32'(3'b010));
    check_eq("z_count", 32'(bus.o_Count), 0);
    check_eq("z_tick2", 32'(bus.o_Tick), 0);
    bus.i_Req = '0;
    step();
    check_eq("z_grant_off", 32'(bus.o_Grant), 0);
    check_eq("z_busy_off", 32'(bus.o_Busy), 0);

    // abort: requester 2 (L=10) wins over 0, drops at count 5, then 0 (L=2) runs
    set_len(2, 12'd10);
    set_len(0, 12'd2);
    bus.i_Req = 3'b101;
    for (int c = 1; c <= 32; c++) begin
      step();
      check_eq("ab_done", 32'(bus.o_Done), (c == 32) ? 1 : 0);
      if (c == 1) check_eq("ab_grant2", 32'(bus.o_Grant), 32'(3'b100));
      if (c == 21) check_eq("ab_count5", 32'(bus.o_Count), 5);
      if (c == 22) bus.i_Req = 3'b001;
      if (c == 23) begin
        check_eq("ab_grant_off", 32'(bus.o_Grant), 0);
        check_eq("ab_busy_off", 32'(bus.o_Busy), 0);
        check_eq("ab_count_hold", 32'(bus.o_Count), 5);
        check_eq("ab_state", 32'(bus.state), 32'(ST_IDLE));
      end
      if (c == 24) begin
        check_eq("ab_grant0", 32'(bus.o_Grant), 1);
        check_eq("ab_count_clr", 32'(bus.o_Count), 0);
      end
      if (c == 32) bus.i_Req = '0;
    end
    step();

    // reset mid-run at count 2, then 0 beats 1
    set_len(1, 12'd10);
    bus.i_Req = 3'b010;
    for (int c = 1; c <= 9; c++) begin
      step();
      if (c == 1) check_eq("mr_grant1", 32'(bus.o_Grant), 32'(3'b010));
    end
    check_eq("mr_count2", 32'(bus.o_Count), 2);
    i_Reset = 1'b1;
    step();
    check_eq("mr_grant", 32'(bus.o_Grant), 0);
    check_eq("mr_busy", 32'(bus.o_Busy), 0);
    check_eq("mr_count", 32'(bus.o_Count), 0);
    check_eq("mr_done", 32'(bus.o_Done), 0);
    check_eq("mr_state", 32'(bus.state), 32'(ST_IDLE));
    i_Reset = 1'b0;
    bus.i_Req = 3'b011;
    step();
    check_eq("mr_first0", 32'(bus.o_Grant), 1);
    bus.i_Req = '0;
    step();
    check_eq("mr_abort_off", 32'(bus.o_Grant), 0);

    // max length 4095: done at 16381, count saturates at L and holds
    set_len(0, 12'd4095);
    bus.i_Req = 3'b001;
    done_cyc = -1;
    for (int c = 1; c <= 16400; c++) begin
      step();
      if (bus.o_Done != '0 && done_cyc < 0) done_cyc = c;
      if (c == 16380) begin
        check_eq("mx_count4094", 32'(bus.o_Count), 4094);
        check_eq("mx_busy", 32'(bus.o_Busy), 1);
      end
      if (c == 16381) begin
        check_eq("mx_count4095", 32'(bus.o_Count), 4095);
        bus.i_Req = '0;
      end
      if (c == 16382) check_eq("mx_busy_off", 32'(bus.o_Busy), 0);
    end
    check_eq("mx_done_cycle", 32'(done_cyc), 16381);
    check_eq("mx_count_hold", 32'(bus.o_Count), 4095);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
